// File: rtl/lab3_mem_line_mem_responder.sv
// rtl/lab3_mem_line_mem_responder.sv - line-organized backing-store responder for the cache's memory streams
//
// Ports:
//   clk             clock, all state updates on the rising edge
//   reset           asynchronous active-low reset
//   memreq_val/rdy  request handshake; rdy is high only while idle
//   memreq_type     0 READ, 1 WRITE, 2 WRITE_INIT, others illegal
//   memreq_opaque   tag echoed in the response
//   memreq_addr     byte address; line index from addr[4 +: log2(lines)], word from addr[3:2]
//   memreq_len      4 selects a single 32-bit word, anything else a full 16 B line
//   memreq_data     write data (word accesses use [31:0])
//   memresp_val/rdy response handshake; response held stable until accepted
//   memresp_type/opaque/len  echoed request fields
//   memresp_test    constant 0
//   memresp_data    read data, 0 for writes and illegal types
//   num_reqs        completed response count, wraps at 16 bits

module lab3_mem_line_mem_responder #(
    parameter int p_num_lines = 256,
    parameter int p_latency   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memreq_val,
    output logic         memreq_rdy,
    input  logic [3:0]   memreq_type,
    input  logic [7:0]   memreq_opaque,
    input  logic [31:0]  memreq_addr,
    input  logic [3:0]   memreq_len,
    input  logic [127:0] memreq_data,
    output logic         memresp_val,
    input  logic         memresp_rdy,
    output logic [3:0]   memresp_type,
    output logic [7:0]   memresp_opaque,
    output logic [1:0]   memresp_test,
    output logic [3:0]   memresp_len,
    output logic [127:0] memresp_data,
    output logic [15:0]  num_reqs
);

    localparam int IDX_W = $clog2(p_num_lines);

    // Last value of the latency counter before the response is presented.
    localparam logic [3:0] LAT_LAST = (p_latency > 0) ? 4'(p_latency - 1) : 4'd0;

    localparam logic [3:0] TYPE_READ       = 4'd0;
    localparam logic [3:0] TYPE_WRITE      = 4'd1;
    localparam logic [3:0] TYPE_WRITE_INIT = 4'd2;
    localparam logic [3:0] LEN_WORD        = 4'd4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       lat_q, lat_d;
    logic [3:0]       type_q;
    logic [7:0]       opaque_q;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       wsel_q;
    logic [3:0]       len_q;
    logic [127:0]     data_q;
    logic [127:0]     resp_data_q;
    logic [15:0]      num_reqs_q;

    // Backing store: deliberately not reset.
    logic [127:0]     mem_q [p_num_lines];

    logic             accept;
    logic             commit;
    logic             from_inputs;
    logic [3:0]       c_type;
    logic [3:0]       c_len;
    logic [IDX_W-1:0] c_idx;
    logic [1:0]       c_wsel;
    logic [127:0]     c_data;
    logic             c_word;
    logic             c_read;
    logic             c_write;
    logic [127:0]     rd_line;
    logic [31:0]      rd_word;
    logic             unused_addr_bits;

    assign memreq_rdy  = (state_q == ST_IDLE);
    assign memresp_val = (state_q == ST_RESP);
    assign accept      = memreq_rdy && memreq_val;

    // Commit happens on the edge that enters RESP. With zero latency that is
    // the acceptance edge itself, so the access must use the live request.
    assign commit = (accept && (p_latency == 0))
                 || ((state_q == ST_ACCESS) && (lat_q == LAT_LAST));
    assign from_inputs = (state_q == ST_IDLE);

    always_comb begin
        c_type = type_q;
        c_len  = len_q;
        c_idx  = idx_q;
        c_wsel = wsel_q;
        c_data = data_q;
        if (from_inputs) begin
            c_type = memreq_type;
            c_len  = memreq_len;
            c_idx  = memreq_addr[4 +: IDX_W];
            c_wsel = memreq_addr[3:2];
            c_data = memreq_data;
        end
    end

    assign c_word  = (c_len == LEN_WORD);
    assign c_read  = (c_type == TYPE_READ);
    assign c_write = (c_type == TYPE_WRITE) || (c_type == TYPE_WRITE_INIT);
    assign rd_line = mem_q[c_idx];
    assign rd_word = rd_line[{c_wsel, 5'b0} +: 32];

    // Address bits above the store size and the byte offset never matter.
    assign unused_addr_bits = ^{memreq_addr[31:4+IDX_W], memreq_addr[1:0]};

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            ST_IDLE: begin
                if (memreq_val) begin
                    lat_d   = 4'd0;
                    state_d = (p_latency == 0) ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (lat_q == LAT_LAST) begin
                    state_d = ST_RESP;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            ST_RESP: begin
                if (memresp_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            lat_q       <= 4'd0;
            type_q      <= 4'd0;
            opaque_q    <= 8'd0;
            idx_q       <= '0;
            wsel_q      <= 2'd0;
            len_q       <= 4'd0;
            data_q      <= '0;
            resp_data_q <= '0;
            num_reqs_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (accept) begin
                type_q   <= memreq_type;
                opaque_q <= memreq_opaque;
                idx_q    <= memreq_addr[4 +: IDX_W];
                wsel_q   <= memreq_addr[3:2];
                len_q    <= memreq_len;
                data_q   <= memreq_data;
            end
            if (commit) begin
                if (c_read) begin
                    resp_data_q <= c_word ? {96'b0, rd_word} : rd_line;
                end else begin
                    resp_data_q <= '0;
                end
            end
            if (memresp_val && memresp_rdy) begin
                num_reqs_q <= num_reqs_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && c_write) begin
            if (c_word) begin
                mem_q[c_idx][{c_wsel, 5'b0} +: 32] <= c_data[31:0];
            end else begin
                mem_q[c_idx] <= c_data;
            end
        end
    end

    assign memresp_type   = type_q;
    assign memresp_opaque = opaque_q;
    assign memresp_test   = 2'b00;
    assign memresp_len    = len_q;
    assign memresp_data   = resp_data_q;
    assign num_reqs       = num_reqs_q;

endmodule

// File: tb/tb_lab3_mem_line_mem_responder.sv
// tb/tb_lab3_mem_line_mem_responder.sv - self-checking bench for lab3_mem_line_mem_responder

module tb_lab3_mem_line_mem_responder;

    localparam int LINES = 256;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [3:0]   req_type;
    logic [7:0]   req_opaque;
    logic [31:0]  req_addr;
    logic [3:0]   req_len;
    logic [127:0] req_data;

    logic         val0, rdy0, rval0, rrdy0;
    logic [3:0]   rtype0, rlen0;
    logic [7:0]   ropq0;
    logic [1:0]   rtest0;
    logic [127:0] rdata0;
    logic [15:0]  nreq0;

    logic         val1, rdy1, rval1, rrdy1;
    logic [3:0]   rtype1, rlen1;
    logic [7:0]   ropq1;
    logic [1:0]   rtest1;
    logic [127:0] rdata1;
    logic [15:0]  nreq1;

    lab3_mem_line_mem_responder #(.p_num_lines(LINES), .p_latency(LAT)) dut0 (
        .clk(clk), .reset(reset),
        .memreq_val(val0), .memreq_rdy(rdy0), .memreq_type(req_type),
        .memreq_opaque(req_opaque), .memreq_addr(req_addr), .memreq_len(req_len),
        .memreq_data(req_data),
        .memresp_val(rval0), .memresp_rdy(rrdy0), .memresp_type(rtype0),
        .memresp_opaque(ropq0), .memresp_test(rtest0), .memresp_len(rlen0),
        .memresp_data(rdata0), .num_reqs(nreq0)
    );

    lab3_mem_line_mem_responder #(.p_num_lines(LINES), .p_latency(0)) dut1 (
        .clk(clk), .reset(reset),
        .memreq_val(val1), .memreq_rdy(rdy1), .memreq_type(req_type),
        .memreq_opaque(req_opaque), .memreq_addr(req_addr), .memreq_len(req_len),
        .memreq_data(req_data),
        .memresp_val(rval1), .memresp_rdy(rrdy1), .memresp_type(rtype1),
        .memresp_opaque(ropq1), .memresp_test(rtest1), .memresp_len(rlen1),
        .memresp_data(rdata1), .num_reqs(nreq1)
    );

    int checks   = 0;
    int failures = 0;
    int exp_count0;

    // Reference store for dut0, one 128-bit entry per line.
    logic [127:0] model [LINES];

    // Zero-latency sequence: WRITE_INIT line, READ line, WRITE word2, READ word2.
    logic [3:0]   z_type [4] = '{4'd2, 4'd0, 4'd1, 4'd0};
    logic [31:0]  z_addr [4] = '{32'h40, 32'h40, 32'h48, 32'h4A};
    logic [3:0]   z_len  [4] = '{4'd0, 4'd0, 4'd4, 4'd4};
    logic [127:0] z_data [4] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                                 128'h5555_5555_5555_5555_5555_5555_5555_5555,
                                 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_CAFE_F00D,
                                 128'h0};
    logic [127:0] z_exp  [4] = '{128'h0,
                                 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                                 128'h0,
                                 128'h0000_0000_0000_0000_0000_0000_CAFE_F00D};

    int           r;
    logic [3:0]   rt, rl;
    logic [127:0] old_line;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Applies one request to the reference store and returns the expected response data.
    task automatic model_apply(input logic [3:0] t, input logic [31:0] a, input logic [3:0] l,
                               input logic [127:0] d, output logic [127:0] exp);
        int ln;
        int sh;
        logic [127:0] mask;
        ln   = int'((a >> 4) % 32'(LINES));
        sh   = 32 * int'((a >> 2) & 32'd3);
        mask = 128'hFFFF_FFFF << sh;
        exp  = '0;
        if (t == 4'd0) begin
            exp = (l == 4'd4) ? ((model[ln] >> sh) & 128'hFFFF_FFFF) : model[ln];
        end else if (t == 4'd1 || t == 4'd2) begin
            model[ln] = (l == 4'd4) ? ((model[ln] & ~mask) | ((d & 128'hFFFF_FFFF) << sh)) : d;
        end
    endtask

    // One full transaction on dut0; called #1 after a rising edge.
    task automatic txn0(input logic [3:0] t, input logic [7:0] op, input logic [31:0] a,
                        input logic [3:0] l, input logic [127:0] d, input int hold);
        logic [127:0] exp_data;
        int n;
        n = 0;
        while (!rdy0 && n < 50) begin @(posedge clk); #1; n++; end
        check("req_rdy_idle", 128'(rdy0), 128'(1));
        req_type = t; req_opaque = op; req_addr = a; req_len = l; req_data = d;
        val0 = 1'b1;
        @(posedge clk); #1;
        val0 = 1'b0;
        req_type = 4'($urandom); req_opaque = 8'($urandom); req_addr = $urandom;
        req_len = 4'($urandom); req_data = {$urandom, $urandom, $urandom, $urandom};
        model_apply(t, a, l, d, exp_data);
        n = 0;
        while (!rval0 && n < 50) begin
            check("req_rdy_busy", 128'(rdy0), 128'(0));
            @(posedge clk); #1; n++;
        end
        check("latency", 128'(n), 128'(LAT));
        check("resp_type", 128'(rtype0), 128'(t));
        check("resp_opaque", 128'(ropq0), 128'(op));
        check("resp_len", 128'(rlen0), 128'(l));
        check("resp_test", 128'(rtest0), 128'(0));
        check("resp_data", rdata0, exp_data);
        check("req_rdy_resp", 128'(rdy0), 128'(0));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_val", 128'(rval0), 128'(1));
            check("bp_data", rdata0, exp_data);
            check("bp_req_rdy", 128'(rdy0), 128'(0));
            check("bp_count", 128'(nreq0), 128'(16'(exp_count0)));
        end
        rrdy0 = 1'b1;
        @(posedge clk); #1;
        rrdy0 = 1'b0;
        exp_count0++;
        check("post_val", 128'(rval0), 128'(0));
        check("post_req_rdy", 128'(rdy0), 128'(1));
        check("num_reqs", 128'(nreq0), 128'(16'(exp_count0)));
    endtask

    initial begin
        reset = 1'b0;
        val0 = 1'b0; rrdy0 = 1'b0; val1 = 1'b0; rrdy1 = 1'b0;
        req_type = '0; req_opaque = '0; req_addr = '0; req_len = '0; req_data = '0;
        exp_count0 = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_rdy", 128'(rdy0), 128'(1));
        check("rst_resp_val", 128'(rval0), 128'(0));
        check("rst_type", 128'(rtype0), 128'(0));
        check("rst_opaque", 128'(ropq0), 128'(0));
        check("rst_test", 128'(rtest0), 128'(0));
        check("rst_len", 128'(rlen0), 128'(0));
        check("rst_data", rdata0, 128'(0));
        check("rst_num_reqs", 128'(nreq0), 128'(0));
        check("rst_num_reqs_l0", 128'(nreq1), 128'(0));
        reset = 1'b1;
        @(posedge clk); #1;

        // Zero latency: response one cycle after acceptance, a new request every two cycles.
        val1 = 1'b1; rrdy1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_type = z_type[i]; req_opaque = 8'(8'h40 + i); req_addr = z_addr[i];
            req_len = z_len[i]; req_data = z_data[i];
            check("l0_req_rdy", 128'(rdy1), 128'(1));
            @(posedge clk); #1;
            check("l0_resp_val", 128'(rval1), 128'(1));
            check("l0_resp_type", 128'(rtype1), 128'(z_type[i]));
            check("l0_resp_opaque", 128'(ropq1), 128'(8'(8'h40 + i)));
            check("l0_resp_data", rdata1, z_exp[i]);
            check("l0_req_rdy_resp", 128'(rdy1), 128'(0));
            @(posedge clk); #1;
            check("l0_resp_val_low", 128'(rval1), 128'(0));
            check("l0_count", 128'(nreq1), 128'(i + 1));
        end
        val1 = 1'b0; rrdy1 = 1'b0;

        // Line write-init then read-back.
        txn0(4'd2, 8'h05, 32'h100, 4'd0, 128'h33333333_22222222_11111111_00000000, 0);
        txn0(4'd0, 8'h06, 32'h100, 4'd0, 128'h0, 0);
        // Word write (upper data bits must be ignored), line and word read-back.
        txn0(4'd1, 8'h07, 32'h108, 4'd4, 128'hAAAA_AAAA_BBBB_BBBB_CCCC_CCCC_DEAD_BEEF, 0);
        txn0(4'd0, 8'h08, 32'h100, 4'd0, 128'h0, 0);
        txn0(4'd0, 8'h09, 32'h10B, 4'd4, 128'h0, 0);
        // Backpressure for five cycles.
        txn0(4'd0, 8'h0A, 32'h100, 4'd0, 128'h0, 5);
        // Address wrap: 0x1010 and 0x0010 are the same line.
        txn0(4'd1, 8'h0B, 32'h0000_1010, 4'd0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0);
        txn0(4'd0, 8'h0C, 32'h0000_0010, 4'd0, 128'h0, 0);
        // Illegal types leave the store untouched and return zero.
        txn0(4'd3, 8'h0D, 32'h100, 4'd0, 128'hFFFF, 0);
        txn0(4'd15, 8'h0E, 32'h104, 4'd4, 128'hFFFF, 1);
        txn0(4'd0, 8'h0F, 32'h100, 4'd0, 128'h0, 0);

        // Reset pulsed while the write is in ACCESS: no response, no write.
        old_line = model[16];
        req_type = 4'd1; req_opaque = 8'h10; req_addr = 32'h100; req_len = 4'd0;
        req_data = 128'h9999_9999_9999_9999_9999_9999_9999_9999;
        check("ra_req_rdy", 128'(rdy0), 128'(1));
        val0 = 1'b1;
        @(posedge clk); #1;
        val0 = 1'b0;
        check("ra_in_access", 128'(rdy0), 128'(0));
        reset = 1'b0;
        #2;
        check("ra_rst_req_rdy", 128'(rdy0), 128'(1));
        check("ra_rst_resp_val", 128'(rval0), 128'(0));
        reset = 1'b1;
        exp_count0 = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("ra_no_resp", 128'(rval0), 128'(0));
        end
        check("ra_num_reqs", 128'(nreq0), 128'(0));
        txn0(4'd0, 8'h11, 32'h100, 4'd0, 128'h0, 0);
        check("ra_model_kept", model[16], old_line);

        // Randomized traffic over lines 0..15 with random upper address bits.
        for (int i = 0; i < 16; i++) begin
            txn0(4'd2, 8'(i), ($urandom & 32'hFFFF_F00F) | (32'(i) << 4), 4'd0,
                 {$urandom, $urandom, $urandom, $urandom}, 0);
        end
        for (int k = 0; k < 40; k++) begin
            r  = int'($urandom_range(0, 9));
            rt = (r < 5) ? 4'd0 : (r < 7) ? 4'd1 : (r == 7) ? 4'd2 : 4'($urandom_range(3, 15));
            rl = ($urandom_range(0, 1) == 1) ? 4'd4 : 4'($urandom_range(0, 15));
            txn0(rt, 8'($urandom), ($urandom & 32'hFFFF_F00F) | (32'($urandom_range(0, 15)) << 4),
                 rl, {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
